// File: rtl/bht_pkg.sv
// Shared constants and types for the branch history cache controller.
package bht_pkg;
  localparam int INDEX_WIDTH = 4;
  localparam int PC_WIDTH    = 10;
  localparam int TAG_SIZE    = PC_WIDTH - INDEX_WIDTH;
  localparam int CACHE_SIZE  = 1 << INDEX_WIDTH;
  localparam int HIST_W      = 3;

  typedef enum logic {INIT, RUN} state_e;

  typedef struct packed {
    logic [TAG_SIZE-1:0]    tag;
    logic [INDEX_WIDTH-1:0] index;
    logic                   taken;
  } upd_entry_t;

  // Two or more taken outcomes in the history predicts taken.
  function automatic logic hist_taken(input logic [HIST_W-1:0] h);
    return (h[0] & h[1]) | (h[0] & h[2]) | (h[1] & h[2]);
  endfunction
endpackage

// File: rtl/bht_update_fifo.sv
// Small FIFO of resolved-branch updates waiting for the cache port.
module bht_update_fifo
  import bht_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  upd_entry_t din_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output upd_entry_t head_o
);
  localparam int PW = $clog2(DEPTH);

  upd_entry_t     mem_q [DEPTH];
  logic [PW-1:0]  wr_q, rd_q;
  logic [PW:0]    cnt_q;

  // DEPTH is a power of two, so pointers wrap by plain overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      if (push_i && !pop_i)      cnt_q <= cnt_q + 1'b1;
      else if (pop_i && !push_i) cnt_q <= cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_q] <= din_i;
  end

  assign full_o  = (cnt_q == (PW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign head_o  = mem_q[rd_q];
endmodule

// File: rtl/bht_controller.sv
// Branch history cache sequencer: init sweep, then one granted access per
// cycle shared between fetch lookups and buffered execute updates.
module bht_controller
  import bht_pkg::*;
#(
  parameter int UPD_DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lookup_valid,
  input  logic [PC_WIDTH-1:0]    lookup_pc,
  output logic                   lookup_ready,
  output logic                   pred_valid,
  output logic                   pred_hit,
  output logic                   pred_taken,
  output logic [HIST_W-1:0]      pred_history,
  input  logic                   upd_valid,
  input  logic [PC_WIDTH-1:0]    upd_pc,
  input  logic                   upd_taken,
  output logic                   upd_ready,
  output logic [INDEX_WIDTH-1:0] cache_addr,
  output logic                   cache_we,
  output logic                   cache_wvalid,
  output logic [TAG_SIZE-1:0]    cache_wtag,
  output logic [HIST_W-1:0]      cache_whistory,
  input  logic                   cache_rvalid,
  input  logic [TAG_SIZE-1:0]    cache_rtag,
  input  logic [HIST_W-1:0]      cache_rhistory,
  output logic                   init_done,
  output logic                   evict
);
  state_e                 state_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic                   pred_valid_q, pred_hit_q, pred_taken_q, evict_q;
  logic [HIST_W-1:0]      pred_hist_q;
  logic                   pred_valid_d, pred_hit_d, pred_taken_d, evict_d;
  logic [HIST_W-1:0]      pred_hist_d;

  logic       fifo_full, fifo_empty, push, pop, run, lk_go, lk_hit, up_hit;
  upd_entry_t head, din;

  assign din = '{tag:   upd_pc[PC_WIDTH-1:INDEX_WIDTH],
                 index: upd_pc[INDEX_WIDTH-1:0],
                 taken: upd_taken};

  bht_update_fifo #(.DEPTH(UPD_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .head_o  (head)
  );

  // A full FIFO blocks lookups so the head is guaranteed the port.
  assign run          = rst && (state_q == RUN);
  assign init_done    = run;
  assign lookup_ready = run && !fifo_full;
  assign upd_ready    = run && !fifo_full;
  assign lk_go        = lookup_valid && lookup_ready;
  assign pop          = run && !lk_go && !fifo_empty;
  assign push         = upd_valid && upd_ready;
  assign lk_hit       = cache_rvalid && (cache_rtag == lookup_pc[PC_WIDTH-1:INDEX_WIDTH]);
  assign up_hit       = cache_rvalid && (cache_rtag == head.tag);

  always_comb begin
    cache_addr     = '0;
    cache_we       = 1'b0;
    cache_wvalid   = 1'b0;
    cache_wtag     = '0;
    cache_whistory = '0;
    pred_valid_d   = lk_go;
    pred_hit_d     = lk_go && lk_hit;
    pred_taken_d   = pred_hit_d && hist_taken(cache_rhistory);
    pred_hist_d    = pred_hit_d ? cache_rhistory : '0;
    evict_d        = pop && cache_rvalid && !up_hit;
    if (rst) begin
      if (state_q == INIT) begin
        cache_addr = idx_q;
        cache_we   = 1'b1;
      end else if (lk_go) begin
        cache_addr = lookup_pc[INDEX_WIDTH-1:0];
      end else if (pop) begin
        cache_addr     = head.index;
        cache_we       = 1'b1;
        cache_wvalid   = 1'b1;
        cache_wtag     = head.tag;
        cache_whistory = up_hit ? {cache_rhistory[HIST_W-2:0], head.taken}
                                : {{(HIST_W-1){1'b0}}, head.taken};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= INIT;
      idx_q   <= '0;
    end else if (state_q == INIT) begin
      idx_q <= idx_q + 1'b1;
      if (idx_q == INDEX_WIDTH'(CACHE_SIZE - 1)) state_q <= RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pred_valid_q <= 1'b0;
      pred_hit_q   <= 1'b0;
      pred_taken_q <= 1'b0;
      pred_hist_q  <= '0;
      evict_q      <= 1'b0;
    end else begin
      pred_valid_q <= pred_valid_d;
      pred_hit_q   <= pred_hit_d;
      pred_taken_q <= pred_taken_d;
      pred_hist_q  <= pred_hist_d;
      evict_q      <= evict_d;
    end
  end

  assign pred_valid   = pred_valid_q;
  assign pred_hit     = pred_hit_q;
  assign pred_taken   = pred_taken_q;
  assign pred_history = pred_hist_q;
  assign evict        = evict_q;
endmodule

// File: tb/tb_bht_controller.sv
// Random + directed bench for bht_controller against a queue/array reference
// model of the cache table and update FIFO.
module tb_bht_controller;
  localparam int DEPTH = 2;

  logic       clk = 1'b0;
  logic       rst, lookup_valid, upd_valid, upd_taken, scramble;
  logic [9:0] lookup_pc, upd_pc;
  logic       lookup_ready, pred_valid, pred_hit, pred_taken, upd_ready;
  logic [2:0] pred_history, cache_whistory, cache_rhistory;
  logic [3:0] cache_addr;
  logic       cache_we, cache_wvalid, cache_rvalid, init_done, evict;
  logic [5:0] cache_wtag, cache_rtag;

  logic       mem_v    [16];
  logic [5:0] mem_tag  [16];
  logic [2:0] mem_hist [16];

  always #5 clk = ~clk;

  bht_controller #(.UPD_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .lookup_valid(lookup_valid), .lookup_pc(lookup_pc), .lookup_ready(lookup_ready),
    .pred_valid(pred_valid), .pred_hit(pred_hit), .pred_taken(pred_taken),
    .pred_history(pred_history),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_ready(upd_ready),
    .cache_addr(cache_addr), .cache_we(cache_we), .cache_wvalid(cache_wvalid),
    .cache_wtag(cache_wtag), .cache_whistory(cache_whistory),
    .cache_rvalid(cache_rvalid), .cache_rtag(cache_rtag), .cache_rhistory(cache_rhistory),
    .init_done(init_done), .evict(evict)
  );

  // The physical cache: combinational read, posedge write; starts with garbage.
  assign cache_rvalid   = mem_v[cache_addr];
  assign cache_rtag     = mem_tag[cache_addr];
  assign cache_rhistory = mem_hist[cache_addr];

  always @(posedge clk) begin
    if (scramble) begin
      for (int k = 0; k < 16; k++) begin
        mem_v[k]    <= 1'b1;
        mem_tag[k]  <= 6'($urandom);
        mem_hist[k] <= 3'($urandom);
      end
    end else if (cache_we) begin
      mem_v[cache_addr]    <= cache_wvalid;
      mem_tag[cache_addr]  <= cache_wtag;
      mem_hist[cache_addr] <= cache_whistory;
    end
  end

  int n_vec = 0, n_err = 0, cyc_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc_n, got, exp);
    end
  endtask

  // Reference model state
  bit          m_init = 1'b1;
  int          m_cnt  = 0;
  logic [10:0] m_q[$];
  bit          rt_v [16];
  bit   [5:0]  rt_tag [16];
  bit   [2:0]  rt_h [16];
  bit          e_pv, e_ph, e_pt, e_ev;
  bit   [2:0]  e_phist;

  task automatic model_step();
    bit full, lk, hit;
    int i;
    bit [5:0] t;
    bit [2:0] nh;
    logic [10:0] e;
    chk("pred_valid", pred_valid, e_pv);
    chk("pred_hit", pred_hit, e_ph);
    chk("pred_taken", pred_taken, e_pt);
    chk("pred_hist", pred_history, e_phist);
    chk("evict", evict, e_ev);
    e_pv = 0; e_ph = 0; e_pt = 0; e_phist = 0; e_ev = 0;
    if (!rst) begin
      chk("rst_lr", lookup_ready, 0);
      chk("rst_ur", upd_ready, 0);
      chk("rst_we", cache_we, 0);
      chk("rst_addr", cache_addr, 0);
      chk("rst_done", init_done, 0);
      m_init = 1; m_cnt = 0; m_q.delete();
      return;
    end
    if (m_init) begin
      chk("init_lr", lookup_ready, 0);
      chk("init_ur", upd_ready, 0);
      chk("init_done", init_done, 0);
      chk("init_we", cache_we, 1);
      chk("init_addr", cache_addr, m_cnt);
      chk("init_wv", cache_wvalid, 0);
      chk("init_wtag", cache_wtag, 0);
      chk("init_wh", cache_whistory, 0);
      rt_v[m_cnt] = 0; rt_tag[m_cnt] = 0; rt_h[m_cnt] = 0;
      m_cnt++;
      if (m_cnt == 16) begin m_init = 0; m_cnt = 0; end
      return;
    end
    full = (m_q.size() == DEPTH);
    chk("lr", lookup_ready, !full);
    chk("ur", upd_ready, !full);
    chk("done", init_done, 1);
    lk = lookup_valid && !full;
    e_pv = lk;
    if (lk) begin
      i = lookup_pc % 16;
      t = 6'(lookup_pc / 16);
      chk("lk_we", cache_we, 0);
      chk("lk_addr", cache_addr, i);
      hit = rt_v[i] && rt_tag[i] == t;
      if (hit) begin
        e_ph = 1;
        e_phist = rt_h[i];
        e_pt = ($countones(rt_h[i]) >= 2);
      end
    end else if (m_q.size() > 0) begin
      e = m_q.pop_front();
      i = e[9:0] % 16;
      t = 6'(e[9:0] / 16);
      hit = rt_v[i] && rt_tag[i] == t;
      nh = hit ? 3'((rt_h[i] * 2 + e[10]) % 8) : 3'(e[10]);
      e_ev = rt_v[i] && !hit;
      chk("up_we", cache_we, 1);
      chk("up_addr", cache_addr, i);
      chk("up_wv", cache_wvalid, 1);
      chk("up_wtag", cache_wtag, t);
      chk("up_wh", cache_whistory, nh);
      rt_v[i] = 1; rt_tag[i] = t; rt_h[i] = nh;
    end else begin
      chk("idle_we", cache_we, 0);
    end
    if (upd_valid && !full) m_q.push_back({upd_taken, upd_pc});
  endtask

  task automatic cyc(input bit r, input bit lv, input logic [9:0] lp,
                     input bit uv, input logic [9:0] up, input bit ut);
    rst = r; lookup_valid = lv; lookup_pc = lp;
    upd_valid = uv; upd_pc = up; upd_taken = ut;
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1, 0, 10'h0, 0, 10'h0, 0);
  endtask

  initial begin
    logic [9:0] rp, ru;
    scramble = 1; rst = 0; lookup_valid = 0; lookup_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0;
    @(posedge clk); #1;
    scramble = 0;
    repeat (3) cyc(0, 0, 10'h0, 0, 10'h0, 0);

    // Sweep: model checks we/addr per row; boundary on the 16th cycle
    idle(15);
    chk("done_before_16", init_done, 0);
    idle(1);
    chk("done_at_16", init_done, 1);
    chk("lr_at_16", lookup_ready, 1);

    cyc(1, 1, 10'h123, 0, 10'h0, 0);
    chk("fresh_pv", pred_valid, 1);
    chk("fresh_hit", pred_hit, 0);
    chk("fresh_taken", pred_taken, 0);

    cyc(1, 0, 10'h0, 1, 10'h045, 1); idle(1);
    chk("u1_tag", mem_tag[5], 6'h04);
    chk("u1_hist", mem_hist[5], 3'b001);
    cyc(1, 0, 10'h0, 1, 10'h045, 1); idle(1);
    chk("u2_hist", mem_hist[5], 3'b011);
    cyc(1, 0, 10'h0, 1, 10'h045, 0); idle(1);
    chk("u3_hist", mem_hist[5], 3'b110);
    cyc(1, 1, 10'h045, 0, 10'h0, 0);
    chk("lk45_hit", pred_hit, 1);
    chk("lk45_hist", pred_history, 3'b110);
    chk("lk45_taken", pred_taken, 1);

    cyc(1, 0, 10'h0, 1, 10'h3C5, 1); idle(1);
    chk("evict_pulse", evict, 1);
    chk("evict_tag", mem_tag[5], 6'h3C);
    chk("evict_hist", mem_hist[5], 3'b001);
    idle(1);
    chk("evict_once", evict, 0);

    // Lookups hog the port while two updates fill the FIFO
    cyc(1, 1, 10'h1F0, 1, 10'h2B3, 1);
    cyc(1, 1, 10'h1F1, 1, 10'h2A7, 1);
    chk("full_lr", lookup_ready, 0);
    cyc(1, 1, 10'h1F2, 0, 10'h0, 0);
    chk("lr_back", lookup_ready, 1);
    cyc(1, 1, 10'h1F3, 0, 10'h0, 0);
    cyc(1, 1, 10'h1F4, 0, 10'h0, 0);

    // Reset with 0x2A7 still queued, then again mid-sweep at row 7
    cyc(0, 0, 10'h0, 0, 10'h0, 0);
    cyc(0, 0, 10'h0, 0, 10'h0, 0);
    idle(7);
    chk("sweep_at7_addr", cache_addr, 7);
    chk("sweep_at7_we", cache_we, 1);
    cyc(0, 0, 10'h0, 0, 10'h0, 0);
    cyc(0, 0, 10'h0, 0, 10'h0, 0);
    idle(16);
    chk("restart_done", init_done, 1);
    for (int k = 0; k < 4; k++) begin
      chk("no_stale_we", cache_we, 0);
      idle(1);
    end
    chk("row7_clear", mem_v[7], 0);

    for (int k = 0; k < 3000; k++) begin
      rp = 10'((($urandom_range(0, 3)) << 4) | $urandom_range(0, 15));
      ru = 10'((($urandom_range(0, 3)) << 4) | $urandom_range(0, 15));
      cyc($urandom_range(0, 399) != 0, $urandom_range(0, 9) < 7, rp,
          $urandom_range(0, 1), ru, $urandom_range(0, 1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bht_controller.md
# bht_controller

Sequencer and arbiter for the branch history cache, a 16-row direct-mapped table of valid/tag/3-bit-history rows indexed by the PC. It owns the cache's single access port and shares it between two requesters: fetch-stage prediction lookups and execute-stage resolved-branch updates, which it buffers in a small FIFO. After reset it runs an initialisation sweep that clears every row, then grants exactly one cache access per cycle.

## Interface
- INDEX_WIDTH, 4, cache index bits; CACHE_SIZE = 1 << INDEX_WIDTH
- PC_WIDTH, 10, program-counter width; TAG_SIZE = PC_WIDTH - INDEX_WIDTH
- UPD_DEPTH, 2, update FIFO depth (power of two, ≥2)

Ports:
- clk  in  1  clock, all state on posedge
- rst  in  1  reset, synchronous, active-low
- lookup_valid  in  1  fetch requests a prediction
- lookup_pc  in  PC_WIDTH  PC to predict
- lookup_ready  out  1  lookup accepted this cycle when high with lookup_valid
- pred_valid  out  1  prediction result valid (one-cycle pulse)
- pred_hit  out  1  row valid and tag matched
- pred_taken  out  1  predicted direction
- pred_history  out  3  history of the hit row; 0 on miss
- upd_valid  in  1  resolved branch offered
- upd_pc  in  PC_WIDTH  PC of the resolved branch
- upd_taken  in  1  actual outcome
- upd_ready  out  1  update accepted into FIFO when high with upd_valid
- cache_addr  out  INDEX_WIDTH  row index driven this cycle
- cache_we  out  1  row write strobe
- cache_wvalid  out  1  valid bit to write
- cache_wtag  out  TAG_SIZE  tag to write
- cache_whistory  out  3  history to write
- cache_rvalid  in  1  valid bit of row at cache_addr (combinational read)
- cache_rtag  in  TAG_SIZE  tag of row at cache_addr
- cache_rhistory  in  3  history of row at cache_addr
- init_done  out  1  high once the sweep completes
- evict  out  1  one-cycle pulse: an update replaced a valid row with a different tag

## Operation
- States: INIT, RUN.
- INIT: an index counter sweeps 0..CACHE_SIZE-1, one row per cycle, with cache_we=1, wvalid=0, wtag=0, whistory=0. After the write to the last row, the block enters RUN and asserts init_done. lookup_ready=upd_ready=0 throughout INIT.
- RUN, FIFO: upd_ready = !fifo_full. A push and a pop in the same cycle leave the count unchanged. Push while full cannot occur, because ready is low.
- RUN, port grant, one access per cycle:
  - lookup_ready = !fifo_full.
  - If lookup_valid && lookup_ready, the lookup owns the port.
  - Otherwise, if the FIFO is non-empty, the FIFO head owns the port and is popped.
  - When full, updates win, which guarantees lookups cannot starve updates.
- Lookup: cache_addr = lookup_pc[INDEX_WIDTH-1:0].
  - Hit = rvalid && rtag == lookup_pc[PC_WIDTH-1:INDEX_WIDTH].
  - pred_taken = hit && (popcount(rhistory) ≥ 2).
  - pred_history = hit ? rhistory : 0.
- Update (single-cycle read-modify-write on the head entry):
  - Hit: write history = {rhistory[1:0], taken}, keeping the same tag, valid=1.
  - Miss: write tag = head tag, history = {2'b00, taken}, valid=1.
  - A miss on a row with rvalid=1 sets evict the next cycle.
- There is no forwarding from FIFO contents to lookups. A lookup may observe history that does not yet include queued updates; this is intended.
- Reset while low, at any point (including mid-sweep or with the FIFO non-empty): state returns to INIT, the sweep counter returns to 0, and the FIFO is emptied. Queued updates are discarded.

## Timing
- Reset values: lookup_ready, upd_ready, pred_valid, pred_hit, pred_taken, pred_history, init_done, evict all 0. cache_we is forced to 0 while rst is low, and cache_addr is 0.
- cache_* outputs are combinational from state, lookup inputs and FIFO head, within the same cycle as the grant.
- pred_* outputs are registered: pred_valid rises exactly 1 cycle after the accepting edge and lasts 1 cycle.
- evict is registered, 1 cycle after the update write edge.
- Update latency: the row is written no earlier than 1 cycle after acceptance, and no later than the first cycle without a granted lookup.
- First RUN cycle is CACHE_SIZE cycles after rst rises, i.e. 16 with default parameters.

## Structure
- Package bht_pkg holds:
  - INDEX_WIDTH, PC_WIDTH, TAG_SIZE and CACHE_SIZE;
  - the state enum {INIT, RUN};
  - the packed struct upd_entry_t {tag, index, taken}.
- Sub-module bht_update_fifo: parameterised UPD_DEPTH FIFO of upd_entry_t with push, pop, full, empty and head. Pointers wrap modulo UPD_DEPTH.

## Test plan
- Release reset: cache_we=1 for 16 consecutive cycles with cache_addr 0..15, then init_done=1 and lookup_ready=1; all outputs are 0 during reset.
- Lookup on a fresh table with pc=0x123: pred_valid one cycle later, with pred_hit=0 and pred_taken=0.
- Three updates to pc=0x045 with taken=1,1,0, no lookups active: row 5 is written with tag 0x04 and history 001, 011, then 110. A lookup of 0x045 then returns hit=1, history=110, taken=1.
- Continuous lookup_valid while 2 updates are pushed: the FIFO fills, lookup_ready drops, the update drains, and lookup_ready returns the next cycle.
- Row 5 holds tag 0x04 and an update to pc=0x3C5 arrives: evict pulses once, and the row holds tag 0x3C with history 00t.
- Reset asserted mid-sweep at index 7 with 1 queued update: the sweep restarts at 0 and the update is never written.
